// File: rtl/bcd_display_scanner_if.sv
// Bundle of the scanner's data-side signals: scan controls and BCD value in, digit drive out.
// Latency: none, wires only.
// Backpressure: none; the display sink always accepts what is driven.
interface bcd_display_scanner_if;
   logic        en;
   logic        load;
   logic [15:0] value;
   logic        lzb;
   logic [3:0]  bcd;
   logic [3:0]  an;
   logic        frame_start;

   // Side that supplies the value and controls and watches the digit drive
   modport master (
      output en, load, value, lzb,
      input  bcd, an, frame_start
   );

   // The scanner itself
   modport slave (
      input  en, load, value, lzb,
      output bcd, an, frame_start
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-seg scanner with shadow register and leading-zero blanking.
// Latency: an/bcd/frame_start are registered, one cycle behind the slot counters.
// Backpressure: none; en=0 freezes the counters and darkens the display.
module bcd_display_scanner #(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   bcd_display_scanner_if.slave io
);

   localparam int            CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [15:0]   disp_q, disp_d;
   logic [3:0]    an_q, an_d;
   logic [3:0]    bcd_q, bcd_d;
   logic          frame_start_q, frame_start_d;
   logic          tick;
   logic [3:0]    nib;
   logic          upper_zero;
   logic [3:0]    shown;

   // Select the addressed nibble and apply invalid-code and leading-zero blanking
   always_comb begin
      nib        = 4'h0;
      upper_zero = 1'b0;
      case (idx_q)
         2'd0: begin
            nib        = disp_q[3:0];
            upper_zero = 1'b0;             // units digit always shows, even for 0
         end
         2'd1: begin
            nib        = disp_q[7:4];
            upper_zero = (disp_q[15:4] == 12'h000);
         end
         2'd2: begin
            nib        = disp_q[11:8];
            upper_zero = (disp_q[15:8] == 8'h00);
         end
         default: begin
            nib        = disp_q[15:12];
            upper_zero = (disp_q[15:12] == 4'h0);
         end
      endcase
      shown = nib;
      if ((nib > 4'd9) || (io.lzb && upper_zero)) begin
         shown = 4'hF;
      end
   end

   // Prescaler, digit index, tear-free frame update and next registered outputs
   always_comb begin
      tick          = io.en && (cnt_q == CNT_LAST);
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      shadow_d      = shadow_q;
      disp_d        = disp_q;
      frame_start_d = 1'b0;
      an_d          = 4'hF;
      bcd_d         = 4'hF;

      if (io.load) begin
         shadow_d = io.value;
      end
      if (io.en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
      if (tick) begin
         idx_d = idx_q + 2'd1;
         // Only swap the displayed value between frames so a digit never mixes two values
         if (idx_q == 2'd3) begin
            disp_d        = shadow_q;
            frame_start_d = 1'b1;
         end
      end
      // First BLANK cycles of each slot stay dark so the previous digit cannot ghost
      if (io.en && (int'(cnt_q) >= BLANK)) begin
         an_d  = ~(4'b0001 << idx_q);
         bcd_d = shown;
      end
   end

   // State and output registers; reset darkens the display immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= 2'd0;
         shadow_q      <= 16'h0000;
         disp_q        <= 16'h0000;
         an_q          <= 4'hF;
         bcd_q         <= 4'hF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         disp_q        <= disp_d;
         an_q          <= an_d;
         bcd_q         <= bcd_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign io.an          = an_q;
   assign io.bcd         = bcd_q;
   assign io.frame_start = frame_start_q;

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Time-multiplexed driver for a 4-digit common-anode 7-segment display. It accepts a packed 4-digit BCD value and cycles through the digits at a fixed refresh rate. For each digit it presents one BCD nibble to the downstream BCD-to-7-segment decoder and drives the matching active-low anode. Blanked digits are sent as code 4'hF, which the decoder maps to all segments off (7'b1111111).

Parameters:
PRESCALE, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range >= BLANK+2
BLANK, 2, cycles at the start of each slot with all anodes off (anti-ghosting); legal range >= 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; 0 = display dark, counters frozen
load  input  1  one-cycle strobe; captures value into the shadow register
value  input  16  packed BCD; [15:12] = digit 3 (MS), [3:0] = digit 0 (LS)
lzb  input  1  leading-zero blanking enable
bcd  output  4  nibble to the 7-seg decoder; 4'hF = blank
an  output  4  anode selects, active low; an[i] = digit i
frame_start  output  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (async assert, sync release): an=4'b1111, bcd=4'hF, frame_start=0, prescale count=0, idx=0, shadow=16'h0000, disp=16'h0000.
- Shadow register: on a clk edge with load=1, shadow<=value. This happens regardless of en.
- Prescaler: cnt counts 0..PRESCALE-1 while en=1. tick = (cnt==PRESCALE-1) && en. On tick, cnt wraps to 0.
- Digit index idx (2 bits): increments on tick; wraps 3->0.
- Frame boundary: on a tick with idx==3, disp<=shadow (tear-free update) and frame_start pulses 1 in the following cycle, i.e. the first cycle of the idx=0 slot. A load on that same edge is not in disp; it appears one frame later.
- Slot timing, all outputs registered:
  - For slot-local cycles cnt < BLANK: an=4'b1111, bcd=4'hF.
  - For cnt >= BLANK: an = ~(4'b0001 << idx), bcd = digit(disp, idx) after blanking rules.
- Blanking rules, applied to the digit being shown:
  - A nibble > 9 is forced to 4'hF.
  - If lzb=1, digit i (i=3..1) is blanked when it and all higher digits of disp are 0.
  - Digit 0 is never blanked for zero, so 0000 shows "0".
- en=0: cnt and idx hold; next cycle an=4'b1111 and bcd=4'hF; frame_start=0. On en returning to 1, the slot resumes from the held cnt/idx.
- Reset mid-frame: outputs go dark immediately (async). After release, scanning restarts at idx=0, cnt=0 with disp=0.
- Output latency: an and bcd reflect cnt/idx/disp one cycle after the counters change (single register stage).
- Only one anode is ever low in a given cycle.

Test Plan (PRESCALE=4, BLANK=1 unless noted):
- Reset then en=1, load value=16'h1234 once. Over the following frames, after the first frame boundary the per-slot sequence is an=1110/bcd=4, an=1101/bcd=3, an=1011/bcd=2, an=0111/bcd=1. Each slot has 1 dark cycle (an=1111, bcd=F) then 3 lit cycles. frame_start pulses every 16 cycles.
- lzb=1 with value=16'h0050: digits 3 and 2 show bcd=F, digit 1 shows 5, digit 0 shows 0. Repeat with lzb=0: digits 3 and 2 show 0.
- value=16'h0000 with lzb=1: only the digit 0 slot lights, with bcd=0. value=16'hA9FB: digits 3, 1 and 0 show bcd=F and digit 2 shows 9.
- Tear-free update: load 16'h1111, then mid-frame (idx=1) load 16'h2222. Required: remaining slots of the current frame still show 1; the next frame shows 2 on all digits. Also load on the same edge as the frame-boundary tick and confirm that value appears one frame late.
- Drop en for 5 cycles mid-slot (idx=2, cnt=2). Required: an=1111 and bcd=F during the pause, no frame_start. Scanning resumes at idx=2, cnt=2, so the slot completes with its remaining cycles only.
- Assert rst_n=0 asynchronously mid-lit-slot. Required: an=1111 and bcd=F before the next clk edge. After release the first frame is dark-valued (disp=0, showing "0" on digit 0 only if lzb=1). Run once more with BLANK=0 and check that no dark cycles appear.
